// File: rtl/trade_rate_arbiter_if.sv
// Bundles the requester-side and grant-side signals of the shared trade budget arbiter.
// The arbiter side uses the slave modport; the strategy/gateway side uses master.
interface trade_rate_arbiter_if #(
  parameter int N_REQ   = 4,
  parameter int TOKEN_W = 16
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic               enable;
  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   grant;
  logic               grant_valid;
  logic [ID_W-1:0]    grant_id;
  logic [N_REQ-1:0]   deny;
  logic [TOKEN_W-1:0] tokens;
  logic [1:0]         state;
  logic [TOKEN_W-1:0] deny_count;

  modport master (
    output enable, req,
    input  grant, grant_valid, grant_id, deny, tokens, state, deny_count
  );

  modport slave (
    input  enable, req,
    output grant, grant_valid, grant_id, deny, tokens, state, deny_count
  );
endinterface

// File: rtl/trade_rate_arbiter.sv
// Token-bucket rate limiter shared by N_REQ requesters with round-robin fairness.
// At most one grant per cycle, each costing one token; one token refills every REFILL_PERIOD clocks.
module trade_rate_arbiter #(
  parameter int N_REQ         = 4,
  parameter int MAX_TOKENS    = 100,
  parameter int REFILL_PERIOD = 1000,
  parameter int TOKEN_W       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  trade_rate_arbiter_if.slave bus
);

  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(REFILL_PERIOD);

  // Handshake: req is a level sampled on every rising edge; a set grant bit one cycle
  // later means that requester's trade was approved for exactly that cycle. There is no
  // back-pressure on grant; a requester that keeps req high simply competes again.

  typedef enum logic [1:0] {
    ST_ACTIVE   = 2'd0,
    ST_EMPTY    = 2'd1,
    ST_DISABLED = 2'd2
  } state_t;

  state_t             state_q, state_nxt;
  logic [TOKEN_W-1:0] tokens_q, tokens_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic [ID_W-1:0]    rr_q, rr_nxt;
  logic [N_REQ-1:0]   grant_q, grant_nxt;
  logic               valid_q, valid_nxt;
  logic [ID_W-1:0]    id_q, id_nxt;
  logic [N_REQ-1:0]   deny_q, deny_nxt;
  logic [TOKEN_W-1:0] dcnt_q, dcnt_nxt;

  logic               refill;
  logic               refill_add;
  logic               do_grant;
  logic               win_found;
  logic [ID_W-1:0]    win_idx;

  assign refill     = (cnt_q == CNT_W'(REFILL_PERIOD - 1));
  assign refill_add = refill && (tokens_q < TOKEN_W'(MAX_TOKENS));
  assign do_grant   = bus.enable && (tokens_q != '0) && (bus.req != '0);

  // Round-robin search: first set request at or above rr_q, wrapping past N_REQ-1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int unsigned idx;
      idx = (int'(rr_q) + k) % N_REQ;
      if (!win_found && bus.req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    cnt_nxt    = cnt_q;
    rr_nxt     = rr_q;
    grant_nxt  = '0;
    valid_nxt  = 1'b0;
    id_nxt     = id_q;
    deny_nxt   = bus.req;
    dcnt_nxt   = dcnt_q;
    tokens_nxt = tokens_q;

    if (refill) cnt_nxt = '0;
    else        cnt_nxt = cnt_q + CNT_W'(1);

    if (do_grant) begin
      grant_nxt = N_REQ'(1) << win_idx;
      valid_nxt = 1'b1;
      id_nxt    = win_idx;
      deny_nxt  = bus.req & ~(N_REQ'(1) << win_idx);
      if (win_idx == ID_W'(N_REQ - 1)) rr_nxt = '0;
      else                             rr_nxt = win_idx + ID_W'(1);
    end

    // Both terms are judged against the pre-update level, so a full bucket that grants
    // on a refill cycle drops by one, and an empty bucket cannot spend a same-cycle refill.
    tokens_nxt = tokens_q - TOKEN_W'(do_grant) + TOKEN_W'(refill_add);

    if ((deny_nxt != '0) && (dcnt_q != '1)) dcnt_nxt = dcnt_q + TOKEN_W'(1);
  end

  // State reflects the enable input and the bucket level after this edge's update.
  always_comb begin
    state_nxt = ST_ACTIVE;
    if (!bus.enable)            state_nxt = ST_DISABLED;
    else if (tokens_nxt == '0)  state_nxt = ST_EMPTY;
    else                        state_nxt = ST_ACTIVE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACTIVE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tokens_q <= TOKEN_W'(MAX_TOKENS);
      cnt_q    <= '0;
      rr_q     <= '0;
      grant_q  <= '0;
      valid_q  <= 1'b0;
      id_q     <= '0;
      deny_q   <= '0;
      dcnt_q   <= '0;
    end else begin
      tokens_q <= tokens_nxt;
      cnt_q    <= cnt_nxt;
      rr_q     <= rr_nxt;
      grant_q  <= grant_nxt;
      valid_q  <= valid_nxt;
      id_q     <= id_nxt;
      deny_q   <= deny_nxt;
      dcnt_q   <= dcnt_nxt;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = valid_q;
  assign bus.grant_id    = id_q;
  assign bus.deny        = deny_q;
  assign bus.tokens      = tokens_q;
  assign bus.state       = state_q;
  assign bus.deny_count  = dcnt_q;

endmodule
